// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_ctrl.sv
// gf180mcu_fd_sc_mcu9t5v0__clkdiv_ctrl
// Glitch-free programmable clock divider feeding the clkbuf_4 clock tree.
// Z is taken directly from a flop. A new DIV value takes effect only when a
// period starts. A stop request always finishes the current period, so Z is
// left parked low.
//
// Build option: define GF180MCU_FD_SC_MCU9T5V0_CLKDIV_ODD_EN to get odd ratios.
//   defined   : N = DIV+2, H = ceil(N/2), L = floor(N/2); any extra cycle goes in HIGH
//   undefined : N = 2*(DIV+1), H = L = DIV+1; exact 50% duty
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  output logic             Z,
  output logic             BUSY,
  output logic             EDGE
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_div_q;
  logic [WIDTH:0]   r_cnt;   // one bit wider than DIV so it can hold 2^WIDTH
  logic             r_z;
  logic             r_edge;

  logic [WIDTH:0]   w_h_new;  // high-phase length for a period starting now
  logic [WIDTH:0]   w_l_cur;  // low-phase length of the period in progress
  logic             w_cnt_last;

`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKDIV_ODD_EN
  // H = ceil((d+2)/2) = (d+3) >> 1
  function automatic logic [WIDTH:0] f_high(input logic [WIDTH-1:0] d);
    logic [WIDTH+1:0] t;
    t = {2'b00, d} + (WIDTH+2)'(3);
    return t[WIDTH+1:1];
  endfunction

  // L = floor((d+2)/2) = (d+2) >> 1, which is never below 1
  function automatic logic [WIDTH:0] f_low(input logic [WIDTH-1:0] d);
    logic [WIDTH+1:0] t;
    t = {2'b00, d} + (WIDTH+2)'(2);
    return t[WIDTH+1:1];
  endfunction
`else
  // Even-only ratios: both phases last d+1 cycles
  function automatic logic [WIDTH:0] f_high(input logic [WIDTH-1:0] d);
    return {1'b0, d} + (WIDTH+1)'(1);
  endfunction

  function automatic logic [WIDTH:0] f_low(input logic [WIDTH-1:0] d);
    return {1'b0, d} + (WIDTH+1)'(1);
  endfunction
`endif

  assign w_h_new    = f_high(DIV);
  assign w_l_cur    = f_low(r_div_q);
  assign w_cnt_last = (r_cnt == (WIDTH+1)'(1));

  assign Z    = r_z;
  assign BUSY = (r_state != ST_IDLE);
  assign EDGE = r_edge;

  // Phase sequencer. EN is only looked at in IDLE and at the end of LOW.
  // DIV is only looked at when a period starts.
  // NOTE: state is updated with non-blocking assignments, so every branch
  // below reads the register values from before this edge. That is what
  // makes the start/boundary decisions race-free.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= ST_IDLE;
      r_div_q <= '0;
      r_cnt   <= '0;
      r_z     <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_edge <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (EN) begin
            r_state <= ST_HIGH;
            r_div_q <= DIV;
            r_cnt   <= w_h_new;
            r_z     <= 1'b1;
            r_edge  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_cnt_last) begin
            r_state <= ST_LOW;
            r_cnt   <= w_l_cur;
            r_z     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - (WIDTH+1)'(1);
          end
        end
        ST_LOW: begin
          if (w_cnt_last) begin
            if (EN) begin
              // Back-to-back restart with no idle gap
              r_state <= ST_HIGH;
              r_div_q <= DIV;
              r_cnt   <= w_h_new;
              r_z     <= 1'b1;
              r_edge  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - (WIDTH+1)'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_z     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_ctrl.sv
// Scoreboard bench for gf180mcu_fd_sc_mcu9t5v0__clkdiv_ctrl.
// The reference model works one whole period at a time. When a period starts,
// it queues H ones followed by L zeros. Each edge pops one value, which is the
// expected Z for the following cycle.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic z;
    logic busy;
    logic edg;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RN  = 1'b0;
  logic         EN  = 1'b0;
  logic [W-1:0] DIV = '0;
  logic         Z;
  logic         BUSY;
  logic         EDGE;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   pend_q[$];   // remaining Z values of the period in progress

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_ctrl #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RN   (RN),
    .EN   (EN),
    .DIV  (DIV),
    .Z    (Z),
    .BUSY (BUSY),
    .EDGE (EDGE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Model one rising edge, using the inputs the DUT sampled on that edge
  task automatic model_step();
    exp_t e;
    int   d, n, h, l;
    e = '0;
    if (!RN) begin
      pend_q.delete();
    end else begin
      if (pend_q.size() == 0 && EN) begin
        d = int'(DIV);
`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKDIV_ODD_EN
        n = d + 2;
        h = (n + 1) / 2;
        l = n / 2;
`else
        n = 2 * (d + 1);
        h = n / 2;
        l = n / 2;
`endif
        for (int i = 0; i < h; i++) pend_q.push_back(1'b1);
        for (int i = 0; i < l; i++) pend_q.push_back(1'b0);
        e.edg = 1'b1;
      end
      if (pend_q.size() > 0) begin
        e.z    = pend_q.pop_front();
        e.busy = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs, then let the model see the edge that samples them
  task automatic cycle(input logic rn, input logic en, input logic [W-1:0] d);
    RN  = rn;
    EN  = en;
    DIV = d;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  // Monitor: compare every cycle's outputs half a period after the edge
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("z",    int'(Z),    int'(e.z));
      check("busy", int'(BUSY), int'(e.busy));
      check("edge", int'(EDGE), int'(e.edg));
    end
  end

  initial begin
    // Reset held for 3 edges with EN=1, then release and run at period 2
    repeat (3) cycle(1'b0, 1'b1, 4'd0);
    repeat (8) cycle(1'b1, 1'b1, 4'd0);
    // DIV=2: it takes effect at the next boundary
    repeat (14) cycle(1'b1, 1'b1, 4'd2);
    repeat (8) cycle(1'b1, 1'b0, 4'd2);
    // Ratio change 1 -> 3 during HIGH
    cycle(1'b1, 1'b1, 4'd1);
    repeat (20) cycle(1'b1, 1'b1, 4'd3);
    repeat (10) cycle(1'b1, 1'b0, 4'd3);
    // Stop request in the 2nd cycle of HIGH, DIV=2
    cycle(1'b1, 1'b1, 4'd2);
    repeat (10) cycle(1'b1, 1'b0, 4'd2);
`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKDIV_ODD_EN
    repeat (12) cycle(1'b1, 1'b1, 4'd1);
    repeat (4) cycle(1'b1, 1'b0, 4'd1);
    repeat (8) cycle(1'b1, 1'b1, 4'd0);
    repeat (4) cycle(1'b1, 1'b0, 4'd0);
`endif
    // Reset in the 2nd cycle of HIGH with DIV=3, then restart
    cycle(1'b1, 1'b1, 4'd3);
    cycle(1'b0, 1'b1, 4'd3);
    repeat (10) cycle(1'b1, 1'b1, 4'd3);
    // Largest ratio
    repeat (40) cycle(1'b1, 1'b1, 4'd15);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9)  != 0) ? 1'b1 : 1'b0,
            W'($urandom));
    end
    repeat (2) @(negedge CLK);
    check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
